// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared constants for the FFT frame sequencer.
//   State encoding (IDLE, CFG, LOAD, WAIT_OUT), bit positions inside the
//   sticky err vector, and the forward-transform config value.
package fft_ctrl_pkg;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CFG      = 2'd1;
  localparam logic [1:0] S_LOAD     = 2'd2;
  localparam logic [1:0] S_WAIT_OUT = 2'd3;

  localparam int ERR_ALM     = 0;
  localparam int ERR_TIMEOUT = 1;

  localparam logic CFG_FWD = 1'b1;

endpackage

// File: rtl/fft_sample_buf.sv
// fft_sample_buf: 1-entry holding buffer between the ADC sample path and the
// FFT core's input AXI4-Stream.
//   fft_clk, rst_n   clock, synchronous active-low reset
//   en               capture allowed (controller is in LOAD)
//   final_beat       the beat currently held is the last one of the frame
//   sample_in/vld    ADC sample and its valid strobe
//   ready            core tready
//   full             buffer holds a beat (drives tvalid)
//   data             held sample (stable while full and not accepted)
//   accept           beat handed to the core this cycle
//   drop             sample arrived with no room; it is discarded
module fft_sample_buf #(
  parameter int DATA_W = 8
) (
  input  logic              fft_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              final_beat,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_vld,
  input  logic              ready,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic              accept,
  output logic              drop
);

  logic capture;

  assign accept  = full && ready;
  // A slot frees up in the same cycle the held beat drains, except after the
  // frame's final beat: nothing more belongs to this frame.
  assign capture = en && sample_vld && (!full || accept) && !(accept && final_beat);
  assign drop    = en && sample_vld && full && !accept;

  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (capture) begin
      full <= 1'b1;
      data <= sample_in;
    end else if (accept) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for the AXI4-Stream FFT core.
//   Issues one config beat, packs FFT_LEN ADC samples into input beats with
//   tlast on the final one, then waits for the core's output tlast (or a
//   timeout) and reports busy/done/err/ovf.
// Ports:
//   fft_clk, rst_n          clock, synchronous active-low reset
//   fft_en                  start request (rising edge in IDLE)
//   sample_in, sample_vld   ADC sample stream
//   cfg_tvalid, cfg_tdata   config channel to the core
//   s_tvalid/tdata/tlast    data channel to the core, s_tready back
//   m_tvalid, m_tlast       core output stream (observed only)
//   alm                     core alarm bits
//   busy, done, err, ovf    status: busy outside IDLE, done pulse,
//                           sticky {timeout, alarm}, sticky sample drop
// Build option: FFT_CTRL_CONT_EN -- after done with fft_en still high, go
//   straight back to LOAD (config reused) for back-to-back frames.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int   FFT_LEN  = 1024,
  parameter int   DATA_W   = 8,
  parameter logic CFG_MODE = CFG_FWD,
  parameter int   TIMEOUT  = 4096
) (
  input  logic              fft_clk,
  input  logic              rst_n,
  input  logic              fft_en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_vld,
  output logic              cfg_tvalid,
  output logic              cfg_tdata,
  output logic              s_tvalid,
  output logic [31:0]       s_tdata,
  output logic              s_tlast,
  input  logic              s_tready,
  input  logic              m_tvalid,
  input  logic              m_tlast,
  input  logic [2:0]        alm,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              ovf
);

  localparam int CW = $clog2(FFT_LEN);
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [1:0]        state;
  logic              fft_en_d;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     timer;
  logic              buf_full, accept, drop, last_beat, start;
  logic [DATA_W-1:0] buf_data;

  assign start     = fft_en && !fft_en_d;
  assign last_beat = (cnt == CW'(FFT_LEN - 1));

  fft_sample_buf #(.DATA_W(DATA_W)) u_buf (
    .fft_clk    (fft_clk),
    .rst_n      (rst_n),
    .en         (state == S_LOAD),
    .final_beat (last_beat),
    .sample_in  (sample_in),
    .sample_vld (sample_vld),
    .ready      (s_tready),
    .full       (buf_full),
    .data       (buf_data),
    .accept     (accept),
    .drop       (drop)
  );

  assign cfg_tvalid = (state == S_CFG);
  assign cfg_tdata  = cfg_tvalid & CFG_MODE;
  assign s_tvalid   = buf_full;
  assign s_tdata    = {{(32-DATA_W){1'b0}}, buf_data};
  // cnt only moves on accept, so tlast stays put while the core stalls.
  assign s_tlast    = buf_full && last_beat;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge fft_clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fft_en_d <= 1'b0;
      cnt      <= '0;
      timer    <= '0;
      done     <= 1'b0;
      err      <= '0;
      ovf      <= 1'b0;
    end else begin
      fft_en_d <= fft_en;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CFG;
            err   <= '0;
            ovf   <= 1'b0;
          end
        end
        S_CFG: begin
          state <= S_LOAD;
          cnt   <= '0;
        end
        S_LOAD: begin
          if (drop) ovf <= 1'b1;
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              state <= S_WAIT_OUT;
              timer <= '0;
            end
          end
        end
        S_WAIT_OUT: begin
          timer <= timer + 1'b1;
          if (m_tvalid && m_tlast) begin
            done <= 1'b1;
`ifdef FFT_CTRL_CONT_EN
            if (fft_en) begin
              state <= S_LOAD;
              cnt   <= '0;
              err   <= '0;
              ovf   <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err[ERR_TIMEOUT] <= 1'b1;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Alarms are only recorded; the AXI frame is never cut short.
      if (state != S_IDLE && alm != 3'b000) err[ERR_ALM] <= 1'b1;
    end
  end

endmodule
